// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and default parameters for the shared-register write arbiter.
package reg_write_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int N_DEFAULT         = 4;
  localparam int W_DEFAULT         = 8;
  localparam int MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] index
);

  // Scan from the farthest offset down so the closest request to ptr wins last.
  always_comb begin
    int j;
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        valid = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// N requesters share one W-bit register; round-robin grants with bounded bursts.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N         = N_DEFAULT,
  parameter int W         = W_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT,
  parameter int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data_in,
  output logic [N-1:0]    grant,
  output logic [W-1:0]    q,
  output logic            q_wr,
  output logic [IW-1:0]   owner,
  output logic            busy
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_t          state_reg, state_next;
  logic [N-1:0]    grant_reg, grant_next;
  logic [W-1:0]    q_reg, q_next;
  logic            q_wr_reg, q_wr_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic            pick_valid;
  logic [IW-1:0]   pick_index;

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .req   (req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .index (pick_index)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      q_reg     <= '0;
      q_wr_reg  <= 1'b0;
      owner_reg <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      q_reg     <= q_next;
      q_wr_reg  <= q_wr_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    logic leave;
    state_next = state_reg;
    grant_next = grant_reg;
    q_next     = q_reg;
    q_wr_next  = 1'b0;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    leave      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next             = OWN;
          grant_next             = '0;
          grant_next[pick_index] = 1'b1;
          owner_next             = pick_index;
          cnt_next               = '0;
        end
      end
      OWN: begin
        if (req[owner_reg]) begin
          q_next    = data_in[owner_reg*W +: W];
          q_wr_next = 1'b1;
          cnt_next  = cnt_reg + 4'd1;
          leave     = ((cnt_reg + 4'd1) == BURST_LIMIT);
        end else begin
          leave = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Leaving OWN always passes priority to the requester after the owner.
    if (leave) begin
      state_next = IDLE;
      grant_next = '0;
      ptr_next   = (owner_reg == IW'(N - 1)) ? '0 : owner_reg + 1'b1;
    end
  end

  assign grant = grant_reg;
  assign q     = q_reg;
  assign q_wr  = q_wr_reg;
  assign owner = owner_reg;
  assign busy  = (state_reg == OWN);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench: stimulus queues expected writes/grants, a monitor checks them.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   grant;
  logic [W-1:0]   q;
  logic           q_wr;
  logic [1:0]     owner;
  logic           busy;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] g;
    int         gap;
  } gr_t;

  wr_t wq[$];
  gr_t gq[$];
  int  compared   = 0;
  int  mismatched = 0;

  reg_write_arbiter #(.N(N), .W(W), .MAX_BURST(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_in (data_in),
    .grant   (grant),
    .q       (q),
    .q_wr    (q_wr),
    .owner   (owner),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops expectations whenever the DUT writes or raises a new grant.
  logic [3:0] prev_grant = '0;
  int         zero_run   = 0;
  always @(negedge clk) begin
    wr_t ew;
    gr_t eg;
    if (q_wr === 1'b1) begin
      compared++;
      if (wq.size() == 0) begin
        mismatched++;
        $display("FAIL write_unexpected: got q=%h owner=%0d, required no write", q, owner);
      end else begin
        ew = wq.pop_front();
        if (q !== ew.data || owner !== 2'(ew.idx)) begin
          mismatched++;
          $display("FAIL write_data: got q=%h owner=%0d, required q=%h owner=%0d",
                   q, owner, ew.data, ew.idx);
        end else
          $display("write ok: owner=%0d q=%h", owner, q);
      end
    end
    if (grant !== 4'b0000 && prev_grant !== 4'b0000 && grant !== prev_grant) begin
      compared++;
      mismatched++;
      $display("FAIL back_to_back: got grant=%b after %b, required an idle cycle", grant, prev_grant);
    end
    if (grant !== 4'b0000 && prev_grant === 4'b0000) begin
      compared++;
      if (gq.size() == 0) begin
        mismatched++;
        $display("FAIL grant_unexpected: got grant=%b, required none", grant);
      end else begin
        eg = gq.pop_front();
        if (grant !== eg.g || busy !== 1'b1 || (eg.gap >= 0 && zero_run != eg.gap)) begin
          mismatched++;
          $display("FAIL grant_onset: got grant=%b busy=%b gap=%0d, required grant=%b busy=1 gap=%0d",
                   grant, busy, zero_run, eg.g, eg.gap);
        end else
          $display("grant ok: grant=%b gap=%0d", grant, zero_run);
      end
    end
    zero_run   = (grant === 4'b0000) ? zero_run + 1 : 0;
    prev_grant = grant;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else
      $display("check ok: %s = %h", name, act);
  endtask

  task automatic push_w(input int idx, input logic [7:0] d, input int n);
    wr_t e;
    e.idx  = idx;
    e.data = d;
    repeat (n) wq.push_back(e);
  endtask

  task automatic push_g(input logic [3:0] g, input int gap);
    gr_t e;
    e.g   = g;
    e.gap = gap;
    gq.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q"}, 32'(q), 32'h00);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_q_wr"}, 32'(q_wr), 32'h0);
    check({tag, "_owner"}, 32'(owner), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    data_in = '0;
    step(2);
    check_reset_state("reset");
    rst = 1'b0;

    // Requesters 0 and 2: 0 wins first, then ptr=1 skips to 2.
    push_g(4'b0001, -1);
    push_w(0, 8'h10, 4);
    push_g(4'b0100, 1);
    push_w(2, 8'h20, 4);
    req = 4'b0101;
    data_in[0*W +: W] = 8'h10;
    data_in[2*W +: W] = 8'h20;
    step(10);
    req = '0;
    step(3);

    // Burst limit: 4 writes, then a second grant that finds req low and writes nothing.
    push_g(4'b0100, -1);
    push_w(2, 8'hA5, 4);
    push_g(4'b0100, 1);
    req = 4'b0100;
    data_in[2*W +: W] = 8'hA5;
    step(6);
    req = '0;
    step(3);
    check("burst_q", 32'(q), 32'hA5);
    check("burst_grant", 32'(grant), 32'h0);

    // Short burst ended by the requester dropping.
    push_g(4'b0010, -1);
    push_w(1, 8'h3C, 1);
    push_w(1, 8'h3D, 1);
    req = 4'b0010;
    data_in[1*W +: W] = 8'h3C;
    step(2);
    data_in[1*W +: W] = 8'h3D;
    step(1);
    req = '0;
    step(1);
    check("short_grant", 32'(grant), 32'h0);
    check("short_busy", 32'(busy), 32'h0);
    step(3);
    check("short_q_hold", 32'(q), 32'h3D);

    // Fresh reset, then all four requesting: full rotation back to requester 0.
    rst = 1'b1;
    step(1);
    check_reset_state("reset2");
    rst = 1'b0;
    push_g(4'b0001, -1); push_w(0, 8'h40, 4);
    push_g(4'b0010, 1);  push_w(1, 8'h41, 4);
    push_g(4'b0100, 1);  push_w(2, 8'h42, 4);
    push_g(4'b1000, 1);  push_w(3, 8'h43, 4);
    push_g(4'b0001, 1);  push_w(0, 8'h40, 4);
    req = 4'b1111;
    data_in = {8'h43, 8'h42, 8'h41, 8'h40};
    step(25);
    req = '0;
    step(3);

    // Reset in the middle of a burst; next arbitration starts at requester 0.
    push_g(4'b0001, -1);
    push_w(0, 8'hFF, 2);
    req = 4'b0001;
    data_in[0*W +: W] = 8'hFF;
    step(3);
    rst = 1'b1;
    step(1);
    check_reset_state("midrst");
    rst = 1'b0;
    push_g(4'b0010, -1);
    req = 4'b1010;
    data_in[1*W +: W] = 8'h11;
    data_in[3*W +: W] = 8'h33;
    step(1);
    req = '0;
    step(3);

    // Owner 3 while requester 0 toggles with changing data.
    push_g(4'b1000, -1);
    push_w(3, 8'h70, 1);
    push_w(3, 8'h71, 1);
    push_w(3, 8'h72, 1);
    push_w(3, 8'h73, 1);
    req = 4'b1000;
    data_in[3*W +: W] = 8'h70;
    step(1);
    req = 4'b1001; data_in[0*W +: W] = 8'hEE;
    step(1);
    req = 4'b1000; data_in[0*W +: W] = 8'h11; data_in[3*W +: W] = 8'h71;
    step(1);
    req = 4'b1001; data_in[0*W +: W] = 8'h22; data_in[3*W +: W] = 8'h72;
    step(1);
    data_in[0*W +: W] = 8'h33; data_in[3*W +: W] = 8'h73;
    step(1);
    req = '0;
    step(3);
    check("owner3_q", 32'(q), 32'h73);

    step(2);
    check("writes_left", 32'(wq.size()), 32'd0);
    check("grants_left", 32'(gq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
